// File: rtl/trace_event_extractor.sv
// Retired-instruction trace monitor that decodes OpenRISC `l.nop K` software events.
// Each event is queued with its r3 argument, PC and timestamp behind a valid/ready port.
module trace_event_extractor #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] EVENT_MASK = 32'hFFFF_FFFE,
  parameter int          CORE_ID    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trace_valid,
  input  logic [31:0] trace_pc,
  input  logic [31:0] trace_insn,
  input  logic        trace_wben,
  input  logic [4:0]  trace_wbreg,
  input  logic [31:0] trace_wbdata,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [15:0] ev_id,
  output logic [31:0] ev_arg,
  output logic [31:0] ev_pc,
  output logic [31:0] ev_time,
  output logic [15:0] ev_core,
  output logic        terminated,
  output logic [15:0] dropped
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  // Handshake: the head entry is transferred on a clock edge where ev_valid && ev_ready;
  // ev_* hold their value while ev_valid is high and ev_ready is low.

  logic [31:0] shadow_r3;
  logic [31:0] timestamp;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [15:0] id_mem   [FIFO_DEPTH];
  logic [31:0] arg_mem  [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic [31:0] time_mem [FIFO_DEPTH];

  logic [15:0] nop_k;
  logic        is_nop;
  logic        mask_hit;
  logic        detect;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;

  assign nop_k    = trace_insn[15:0];
  assign is_nop   = (trace_insn[31:24] == 8'h15) && (trace_insn[23:16] == 8'h00);
  // Immediates of 32 and above have no mask bit and are always captured.
  assign mask_hit = (nop_k >= 16'd32) || EVENT_MASK[nop_k[4:0]];
  assign detect   = trace_valid && is_nop && (nop_k != 16'd0) && mask_hit && !terminated;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = !empty && ev_ready;
  assign push  = detect && (!full || pop);
  assign drop  = detect && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r3  <= '0;
      timestamp  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      terminated <= 1'b0;
      dropped    <= '0;
    end else begin
      timestamp <= timestamp + 32'd1;
      if (trace_valid && trace_wben && (trace_wbreg == 5'd3)) begin
        shadow_r3 <= trace_wbdata;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Exit latches even when the exit event itself could not be queued.
      if (detect && (nop_k == 16'd1)) begin
        terminated <= 1'b1;
      end
      if (drop && (dropped != 16'hFFFF)) begin
        dropped <= dropped + 16'd1;
      end
    end
  end

  // Storage needs no reset: entries are only visible through a non-empty head.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr]   <= nop_k;
      arg_mem[wr_ptr]  <= shadow_r3;
      pc_mem[wr_ptr]   <= trace_pc;
      time_mem[wr_ptr] <= timestamp;
    end
  end

  assign ev_valid = !empty;
  assign ev_id    = empty ? 16'd0 : id_mem[rd_ptr];
  assign ev_arg   = empty ? 32'd0 : arg_mem[rd_ptr];
  assign ev_pc    = empty ? 32'd0 : pc_mem[rd_ptr];
  assign ev_time  = empty ? 32'd0 : time_mem[rd_ptr];
  assign ev_core  = 16'(CORE_ID);

endmodule

// File: doc/trace_event_extractor.md
Name: trace_event_extractor

Overview:
- Sits directly downstream of a compute tile's execution-trace port (one instance per core). Consumes the per-cycle retired-instruction trace.
- Keeps a shadow copy of GPR r3 and decodes OpenRISC `l.nop K` software events (exit, report, putc, …).
- Queues each event with argument, PC and timestamp in a FIFO behind a valid/ready interface, so a synthesizable debug or host path can replace the simulation-only monitor.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, >=2.
- EVENT_MASK, 32'hFFFF_FFFE, bit K enables capture of `l.nop K` for K<32; K>=32 is always captured. Bit 0 is ignored (plain nop never captured).
- CORE_ID, 0, core index driven on ev_core.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- trace_valid  in  1  instruction retired this cycle
- trace_pc  in  32  PC of retired instruction
- trace_insn  in  32  retired instruction word
- trace_wben  in  1  retired instruction writes a GPR
- trace_wbreg  in  5  written GPR index
- trace_wbdata  in  32  written GPR value
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts head
- ev_id  out  16  nop immediate K
- ev_arg  out  32  r3 value at event
- ev_pc  out  32  event PC
- ev_time  out  32  timestamp at event
- ev_core  out  16  CORE_ID
- terminated  out  1  sticky: exit event (K=1) seen
- dropped  out  16  saturating count of events lost to a full FIFO

Behaviour:
- Reset (rst_n low, async):
  - shadow r3=0, timestamp=0, FIFO empty, terminated=0, dropped=0.
  - ev_valid=0; ev_id/ev_arg/ev_pc/ev_time=0.
  - Reset mid-operation discards all queued events.
- Timestamp:
  - 32-bit free-running counter, +1 every clk after reset.
  - Wraps FFFF_FFFF->0 silently.
- Shadow r3:
  - On trace_valid && trace_wben && trace_wbreg==3, r3 <= trace_wbdata at the clock edge.
  - trace_wben ignored when trace_valid=0.
- Event detect (combinational on the trace inputs):
  - Condition: trace_valid && trace_insn[31:24]==8'h15 && trace_insn[23:16]==0 && K=trace_insn[15:0] != 0 && (K>=32 || EVENT_MASK[K]) && !terminated.
  - ev_arg = shadow r3 before this edge (l.nop never writes r3).
  - ev_time = counter value in the detect cycle.
- Termination:
  - A detected K==1 sets terminated on that edge, even if the event itself is dropped.
  - All later events are ignored (not captured, not counted in dropped).
  - Cleared only by reset.
- FIFO:
  - Push accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs the same cycle (simultaneous push/pop when full succeeds, count unchanged).
  - Otherwise the event is dropped and dropped increments, saturating at 16'hFFFF.
  - Pop when ev_valid && ev_ready. Pop when empty is a no-op.
  - Pointers wrap modulo FIFO_DEPTH.
- Output:
  - ev_valid = !empty; ev_* = head entry, stable while ev_valid && !ev_ready.
  - Latency: event in cycle N with FIFO empty gives ev_valid=1 in cycle N+1. No combinational path from trace inputs to ev_*.
  - Push into an empty FIFO in the same cycle a pop attempt occurs: no pop (ev_valid was 0).
- Throughput: one event per cycle in, one per cycle out.

Test Plan:
- Reset, no traffic -> ev_valid=0, dropped=0, terminated=0; after 10 cycles internal timestamp=10, checked via next event's ev_time.
- Write r3=0x1234_5678 (wbreg=3), next cycle insn=0x1500_0004 at pc=0x100 -> one cycle later ev_valid=1, ev_id=4, ev_arg=0x12345678, ev_pc=0x100.
- insn=0x1500_0000, and insn=0x1500_0003 with EVENT_MASK bit3=0 -> no event; insn=0x1500_0040 -> event ev_id=0x40.
- ev_ready=0, FIFO_DEPTH=8, 10 consecutive events -> 8 queued, dropped=2. Then ev_ready=1 with a simultaneous push -> push accepted, drain order FIFO-preserved.
- Exit: r3=0x2A, insn=0x1500_0001 -> ev_id=1, ev_arg=0x2A, terminated=1; following 0x1500_0004 -> no event, dropped unchanged.
- Assert rst_n low mid-queue with 3 entries -> ev_valid=0 immediately (async), all outputs 0 after release.
